neander_core_param: RTL and testbench
=====================================

Name: neander_core_param

Overview:
- Parametrised, self-contained Neander accumulator core: datapath (PC, AC, RI, REM, NZ, ALU) plus an internal multi-cycle controller FSM.
- Replaces the fixed 8-bit top. Data and address widths are generalised; a SUB instruction is added.
- Memory sits outside the core behind a req/ready handshake, so wait-state memories are supported. A HALT state can be restarted by a run pulse.

Parameters:
- DATA_WIDTH, 8: accumulator, memory word and ALU width. Must be at least 4 and at least ADDR_WIDTH.
- ADDR_WIDTH, 8: PC, REM and memory address width.

Ports:
- clk_geral  in  1  single clock, rising edge.
- reset_geral  in  1  synchronous, active-high reset.
- run  in  1  restart pulse, honoured only in S_HALT.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier, valid only while mem_req=1.
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  DATA_WIDTH  write data (always AC).
- mem_rdata  in  DATA_WIDTH  read data, valid on a handshake cycle.
- mem_ready  in  1  memory completes the access this cycle.
- data_out_geral  out  ADDR_WIDTH  current PC.
- regRi_out  out  4  current opcode, RI[DATA_WIDTH-1:DATA_WIDTH-4].
- ac_out  out  DATA_WIDTH  accumulator.
- nz_out  out  2  {N,Z}.
- halted  out  1  high while in S_HALT.

Behaviour:
- Interface: one clock, clk_geral. reset_geral is synchronous and active-high.
- Reset values: PC=0, AC=0, RI=0, REM=0, N=0, Z=1, state=S_FETCH, halted=0.
- While reset_geral=1, mem_req and mem_we are forced to 0 combinationally. An in-flight access is abandoned without any register update.
- reset has priority over run and over mem_ready.
- Handshake: an access completes on the rising edge where mem_req=1 and mem_ready=1.
  - mem_req, mem_we, mem_addr and mem_wdata are combinational decodes of state and registers.
  - They stay stable until completion.
  - mem_ready is ignored when mem_req=0.
  - mem_ready tied to 1 gives zero-wait operation.
- Opcode encoding: 0 NOP, 1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND, 6 NOT, 7 SUB, 8 JMP, 9 JN, A JZ, F HLT. Opcodes B–E execute as NOP.
- S_FETCH: req, addr=PC, we=0. On completion: RI<=rdata, PC<=PC+1, go to S_DECODE.
- S_DECODE (1 cycle, no request):
  - NOP/undefined: go to S_FETCH.
  - NOT: AC<=~AC, update NZ, go to S_FETCH.
  - HLT: go to S_HALT.
  - JN with N=0, or JZ with Z=0: PC<=PC+1 (skip operand), go to S_FETCH.
  - All other opcodes: go to S_OPER.
- S_OPER: req, addr=PC.
  - On completion for JMP, or JN/JZ taken: PC<=rdata[ADDR_WIDTH-1:0], go to S_FETCH.
  - Otherwise: REM<=rdata[ADDR_WIDTH-1:0], PC<=PC+1, go to S_EXEC.
- S_EXEC: req, addr=REM, we=1 only for STA. On completion:
  - STA: memory is written; no register change.
  - LDA: AC<=rdata.
  - ADD: AC<=AC+rdata, modulo 2^DATA_WIDTH, carry discarded.
  - SUB: AC<=AC-rdata, modulo 2^DATA_WIDTH.
  - OR / AND: bitwise.
  - Then go to S_FETCH.
- NZ update: N=AC_new[DATA_WIDTH-1], Z=(AC_new==0). NZ is updated only by LDA, ADD, SUB, OR, AND, NOT.
- S_HALT: no requests, halted=1, PC holds (points past HLT). run=1 goes to S_FETCH the next cycle. run in any other state is ignored.
- PC wraps from 2^ADDR_WIDTH-1 to 0 on increment.
- Zero-wait cycle counts:
  - NOP, NOT, skipped branch: 2.
  - JMP, taken branch: 3.
  - LDA, STA, ADD, SUB, OR, AND: 4.
  - HLT: 2, then halted.
- Each wait cycle (mem_ready=0 during a request) adds exactly 1 cycle.

Test Plan:
- Reset, zero-wait memory, program LDA 0x80; ADD 0x81; STA 0x82; HLT with mem[80]=0x7F, mem[81]=0x02 -> mem[82]=0x81, N=1, Z=0, halted=1 after 14 cycles, data_out_geral=0x07.
- SUB to zero: AC=0x05, SUB of a word holding 0x05 -> AC=0x00, nz_out=01. AC=0x00 SUB 0x01 -> AC=0xFF, nz_out=10.
- Branches: JZ 0x20 with Z=1 -> PC=0x20 after 3 cycles. JZ with Z=0 -> PC advances by 2 after 2 cycles, with no operand request issued.
- Wait states: mem_ready low for 3 cycles on every access during an LDA -> completes in 4+9=13 cycles; mem_addr/mem_we stable throughout each stalled access.
- Halt/restart: after HLT, hold 5 cycles with run=0 -> no mem_req, PC unchanged. Pulse run -> fetch from PC. Assert run and reset_geral together -> reset state, PC=0.
- Parameter sweep DATA_WIDTH=16, ADDR_WIDTH=10: JMP 0x3FF, then a NOP at 0x3FF -> PC wraps to 0x000. ADD 0xFFFF+0x0001 -> AC=0x0000, Z=1.

Source files
------------

// File: rtl/neander_core_param.sv
// Parametrised Neander accumulator core with an external req/ready memory port.
// The multi-cycle controller is a single FSM, and the datapath registers are updated only on handshake completion.
module neander_core_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_geral,
    input  logic                  reset_geral,
    input  logic                  run,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] data_out_geral,
    output logic [3:0]            regRi_out,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic [1:0]            nz_out,
    output logic                  halted
);

    // state    | meaning
    // S_FETCH  | read instruction at PC, latch opcode, PC+1
    // S_DECODE | one idle cycle: NOT/HLT/NOP/skipped branch resolve here
    // S_OPER   | read operand word at PC (branch target or data address)
    // S_EXEC   | access data at REM (read for ALU ops, write for STA)
    // S_HALT   | no requests; wait for a run pulse
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPER, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_ac;
    logic [3:0]            r_ri;
    logic                  r_n;
    logic                  r_z;
    logic                  r_halted;

    logic                  w_done;
    logic                  w_taken;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [DATA_WIDTH-1:0] w_not;

    assign w_done    = mem_req & mem_ready;
    assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
    assign w_operand = mem_rdata[ADDR_WIDTH-1:0];
    assign w_not     = ~r_ac;
    assign w_taken   = (r_ri == OP_JMP) | ((r_ri == OP_JN) & r_n) | ((r_ri == OP_JZ) & r_z);

    // Only the opcode nibble of RI is ever consumed, so only that is stored.
    always_comb begin
        w_alu = r_ac;
        case (r_ri)
            OP_LDA:  w_alu = mem_rdata;
            OP_ADD:  w_alu = r_ac + mem_rdata;
            OP_SUB:  w_alu = r_ac - mem_rdata;
            OP_OR:   w_alu = r_ac | mem_rdata;
            OP_AND:  w_alu = r_ac & mem_rdata;
            default: w_alu = r_ac;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = (r_state == S_EXEC) ? r_rem : r_pc;
        if (!reset_geral) begin
            case (r_state)
                S_FETCH, S_OPER: mem_req = 1'b1;
                S_EXEC: begin
                    mem_req = 1'b1;
                    mem_we  = (r_ri == OP_STA);
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign mem_wdata      = r_ac;
    assign data_out_geral = r_pc;
    assign regRi_out      = r_ri;
    assign ac_out         = r_ac;
    assign nz_out         = {r_n, r_z};
    assign halted         = r_halted;

    always_ff @(posedge clk_geral) begin
        if (reset_geral) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_rem    <= '0;
            r_ac     <= '0;
            r_ri     <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b1;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_done) begin
                        r_ri    <= mem_rdata[DATA_WIDTH-1:DATA_WIDTH-4];
                        r_pc    <= w_pc_inc;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (r_ri)
                        OP_NOT: begin
                            r_ac    <= w_not;
                            r_n     <= w_not[DATA_WIDTH-1];
                            r_z     <= (w_not == '0);
                            r_state <= S_FETCH;
                        end
                        OP_HLT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        OP_JN, OP_JZ: begin
                            if (w_taken) begin
                                r_state <= S_OPER;
                            end else begin
                                r_pc    <= w_pc_inc;
                                r_state <= S_FETCH;
                            end
                        end
                        OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_SUB, OP_JMP:
                            r_state <= S_OPER;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_OPER: begin
                    if (w_done) begin
                        if (w_taken) begin
                            r_pc    <= w_operand;
                            r_state <= S_FETCH;
                        end else begin
                            r_rem   <= w_operand;
                            r_pc    <= w_pc_inc;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_done) begin
                        if (r_ri != OP_STA) begin
                            r_ac <= w_alu;
                            r_n  <= w_alu[DATA_WIDTH-1];
                            r_z  <= (w_alu == '0);
                        end
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_neander_core_param.sv
// Bench for neander_core_param: an instruction-level model predicts every cycle's memory request and the architectural state.
// Two instances (8/8 and 16/10); the unselected one is held in reset.
module tb_neander_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, run = 1'b0, rdy = 1'b0, sel = 1'b0;
    logic [15:0] rdata = '0;

    logic       req0, we0, hlt0;
    logic [7:0] addr0, wd0, pc0, ac0;
    logic [3:0] ri0;
    logic [1:0] nz0;
    logic        req1, we1, hlt1;
    logic [9:0]  addr1, pc1;
    logic [15:0] wd1, ac1;
    logic [3:0]  ri1;
    logic [1:0]  nz1;
    logic rst0, rst1;
    assign rst0 = rst | sel;
    assign rst1 = rst | ~sel;

    neander_core_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_dut8 (
        .clk_geral(clk), .reset_geral(rst0), .run(run),
        .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_rdata(rdata[7:0]), .mem_ready(rdy),
        .data_out_geral(pc0), .regRi_out(ri0), .ac_out(ac0), .nz_out(nz0), .halted(hlt0));

    neander_core_param #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) u_dut16 (
        .clk_geral(clk), .reset_geral(rst1), .run(run),
        .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_rdata(rdata), .mem_ready(rdy),
        .data_out_geral(pc1), .regRi_out(ri1), .ac_out(ac1), .nz_out(nz1), .halted(hlt1));

    logic        d_req, d_we, d_halt;
    logic [15:0] d_addr, d_wd, d_pc, d_ac;
    logic [3:0]  d_ri;
    logic [1:0]  d_nz;
    always_comb begin
        if (sel) begin
            d_req = req1; d_we = we1; d_halt = hlt1; d_addr = {6'b0, addr1}; d_wd = wd1;
            d_pc = {6'b0, pc1}; d_ac = ac1; d_ri = ri1; d_nz = nz1;
        end else begin
            d_req = req0; d_we = we0; d_halt = hlt0; d_addr = {8'b0, addr0}; d_wd = {8'b0, wd0};
            d_pc = {8'b0, pc0}; d_ac = {8'b0, ac0}; d_ri = ri0; d_nz = nz0;
        end
    end

    // Reference model: architectural state plus the memory image.
    int dw = 8, aw = 8, dmask = 'hFF, amask = 'hFF;
    int mem [1024];
    int m_pc, m_ac, m_n, m_z, m_ri;
    bit m_halt;
    int checks = 0, failures = 0;
    int wait_fixed = -1, rdy_pct = 100, run_noise = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ac = 0; m_n = 0; m_z = 1; m_ri = 0; m_halt = 0;
    endtask

    task automatic check_arch();
        chk("arch_pc", int'(d_pc), m_pc);
        chk("arch_ac", int'(d_ac), m_ac);
        chk("arch_nz", int'(d_nz), (m_n << 1) | m_z);
        chk("arch_ri", int'(d_ri), m_ri);
        chk("arch_halted", int'(d_halt), int'(m_halt));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 0;
    endtask

    task automatic configure(input bit wide);
        sel = wide;
        dw = wide ? 16 : 8;
        aw = wide ? 10 : 8;
        dmask = (1 << dw) - 1;
        amask = (1 << aw) - 1;
    endtask

    // Execute one instruction: expected per-cycle slots, then commit the model.
    task automatic run_instr(output int cyc);
        int op, pc1, opa, nac, npc, n, i, stall;
        int s_acc[4], s_addr[4], s_we[4];
        bit nzupd, wr_mem, rd;
        s_acc = '{default: 0}; s_addr = '{default: 0}; s_we = '{default: 0};
        op = (mem[m_pc] >> (dw - 4)) & 15;
        pc1 = (m_pc + 1) & amask;
        s_acc[0] = 1; s_addr[0] = m_pc; n = 2;
        nac = m_ac; npc = pc1; nzupd = 0; wr_mem = 0; opa = 0;
        case (op)
            6: begin nac = ~m_ac & dmask; nzupd = 1; end
            8, 9, 10: begin
                if (op == 8 || (op == 9 && m_n == 1) || (op == 10 && m_z == 1)) begin
                    s_acc[n] = 1; s_addr[n] = pc1; n++;
                    npc = mem[pc1] & amask;
                end else npc = (pc1 + 1) & amask;
            end
            1, 2, 3, 4, 5, 7: begin
                s_acc[n] = 1; s_addr[n] = pc1; n++;
                opa = mem[pc1] & amask;
                s_acc[n] = 1; s_addr[n] = opa; s_we[n] = (op == 1); n++;
                npc = (pc1 + 1) & amask;
                nzupd = (op != 1);
                case (op)
                    1: wr_mem = 1;
                    2: nac = mem[opa] & dmask;
                    3: nac = (m_ac + mem[opa]) & dmask;
                    4: nac = m_ac | mem[opa];
                    5: nac = m_ac & mem[opa];
                    default: nac = (m_ac - mem[opa]) & dmask;
                endcase
            end
            default: ;
        endcase
        i = 0; cyc = 0; stall = 0;
        while (i < n && cyc < 400) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("halted_busy", int'(d_halt), 0);
            if (s_acc[i] != 0) begin
                chk("req", int'(d_req), 1);
                chk("addr", int'(d_addr), s_addr[i]);
                chk("we", int'(d_we), s_we[i]);
                chk("wdata", int'(d_wd), m_ac);
            end else chk("req_idle", int'(d_req), 0);
            if (wait_fixed >= 0) rd = (stall >= wait_fixed);
            else rd = ($urandom_range(0, 99) < rdy_pct);
            rdy = rd;
            if (s_acc[i] != 0 && s_we[i] == 0) rdata = 16'(mem[s_addr[i]]);
            else rdata = 16'($urandom) & 16'(dmask);
            run = ($urandom_range(0, 99) < run_noise);
            if (s_acc[i] == 0 || rd) begin i++; stall = 0; end
            else stall++;
            cyc++;
        end
        if (i < n) chk("instr_timeout", i, n);
        @(posedge clk); #1;
        if (wr_mem) mem[opa] = m_ac;
        m_ac = nac;
        if (nzupd) begin m_n = (nac >> (dw - 1)) & 1; m_z = (nac == 0); end
        m_pc = npc;
        m_ri = op;
        if (op == 15) m_halt = 1;
        check_arch();
    endtask

    task automatic hold_halt(input int k);
        repeat (k) begin
            @(negedge clk);
            rst = 1'b0; run = 1'b0; rdy = 1'($urandom);
            #1;
            chk("halt_hold_halted", int'(d_halt), 1);
            chk("halt_hold_req", int'(d_req), 0);
            chk("halt_hold_pc", int'(d_pc), m_pc);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b0; run = 1'b1; rdy = 1'($urandom);
        #1;
        chk("restart_pre_halted", int'(d_halt), 1);
        @(posedge clk); #1;
        m_halt = 0;
        chk("restart_halted", int'(d_halt), 0);
        chk("restart_pc", int'(d_pc), m_pc);
    endtask

    // One reset cycle with ready high, so a pending access would complete if reset lost priority.
    task automatic do_reset(input bit with_run);
        @(negedge clk);
        rst = 1'b1; run = with_run; rdy = 1'b1;
        #1;
        chk("reset_req_forced", int'(d_req), 0);
        chk("reset_we_forced", int'(d_we), 0);
        @(posedge clk); #1;
        model_reset();
        chk("reset_req", int'(d_req), 0);
        check_arch();
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, tot;
        configure(1'b0);
        model_reset();
        run_noise = 25;

        // LDA 80; ADD 81; STA 82; HLT
        clear_mem();
        mem['h00] = 'h20; mem['h01] = 'h80; mem['h02] = 'h30; mem['h03] = 'h81;
        mem['h04] = 'h10; mem['h05] = 'h82; mem['h06] = 'hF0;
        mem['h80] = 'h7F; mem['h81] = 'h02;
        do_reset(1'b0);
        chk("reset_ac_lit", int'(d_ac), 0);
        chk("reset_nz_lit", int'(d_nz), 1);
        tot = 0;
        repeat (4) begin run_instr(c); tot += c; end
        chk("t1_cycles", tot, 14);
        chk("t1_mem82", mem['h82], 'h81);
        chk("t1_ac", int'(d_ac), 'h81);
        chk("t1_nz", int'(d_nz), 2);
        chk("t1_halted", int'(d_halt), 1);
        chk("t1_pc", int'(d_pc), 7);

        // SUB, branches, wait states, halt/restart
        clear_mem();
        mem['h00] = 'h20; mem['h01] = 'h90; mem['h02] = 'h70; mem['h03] = 'h90;
        mem['h04] = 'h70; mem['h05] = 'h91; mem['h06] = 'h20; mem['h07] = 'h92;
        mem['h08] = 'hA0; mem['h09] = 'h20;
        mem['h20] = 'h20; mem['h21] = 'h91; mem['h22] = 'hA0; mem['h23] = 'h40;
        mem['h24] = 'h20; mem['h25] = 'h90; mem['h26] = 'hF0; mem['h27] = 'h00;
        mem['h90] = 'h05; mem['h91] = 'h01; mem['h92] = 'h00;
        do_reset(1'b0);
        run_instr(c);
        run_instr(c);
        chk("sub_zero_ac", int'(d_ac), 0);
        chk("sub_zero_nz", int'(d_nz), 1);
        run_instr(c);
        chk("sub_neg_ac", int'(d_ac), 'hFF);
        chk("sub_neg_nz", int'(d_nz), 2);
        run_instr(c);
        run_instr(c);
        chk("jz_taken_cycles", c, 3);
        chk("jz_taken_pc", int'(d_pc), 'h20);
        run_instr(c);
        run_instr(c);
        chk("jz_skip_cycles", c, 2);
        chk("jz_skip_pc", int'(d_pc), 'h24);
        wait_fixed = 3;
        run_instr(c);
        chk("wait_lda_cycles", c, 13);
        wait_fixed = -1;
        run_instr(c);
        chk("hlt_cycles", c, 2);
        hold_halt(5);
        chk("halt_pc_lit", int'(d_pc), 'h27);
        restart();
        run_instr(c);
        chk("nop_cycles", c, 2);
        chk("nop_pc", int'(d_pc), 'h28);
        do_reset(1'b0);
        for (int k = 0; k < 20 && !m_halt; k++) run_instr(c);
        chk("rerun_halted", int'(m_halt), 1);
        do_reset(1'b1);
        chk("run_reset_pc", int'(d_pc), 0);
        chk("run_reset_halted", int'(d_halt), 0);

        // random program, random wait states, 8/8
        rdy_pct = 60;
        for (int i = 0; i < 256; i++) mem[i] = int'($urandom) & dmask;
        do_reset(1'b0);
        for (int k = 0; k < 250; k++) begin
            if (m_halt) begin hold_halt(int'($urandom_range(0, 3))); restart(); end
            else run_instr(c);
        end

        // 16/10 instance: carry wrap and PC wrap
        @(negedge clk); rst = 1'b1;
        configure(1'b1);
        rdy_pct = 100;
        clear_mem();
        mem[0] = 'h2000; mem[1] = 'h100; mem[2] = 'h3000; mem[3] = 'h101;
        mem[4] = 'h8000; mem[5] = 'h3FF; mem['h3FF] = 'h0000;
        mem['h100] = 'hFFFF; mem['h101] = 'h0001;
        do_reset(1'b0);
        run_instr(c);
        run_instr(c);
        chk("w16_add_ac", int'(d_ac), 0);
        chk("w16_add_nz", int'(d_nz), 1);
        run_instr(c);
        chk("w16_jmp_cycles", c, 3);
        chk("w16_jmp_pc", int'(d_pc), 'h3FF);
        run_instr(c);
        chk("w16_wrap_pc", int'(d_pc), 0);

        rdy_pct = 60;
        for (int i = 0; i < 1024; i++) mem[i] = int'($urandom) & dmask;
        do_reset(1'b0);
        for (int k = 0; k < 250; k++) begin
            if (m_halt) begin hold_halt(int'($urandom_range(0, 3))); restart(); end
            else run_instr(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
